// File: rtl/is_uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller slice.
package is_pkg_uart_controller;

  // Width of the baud divider counter; the divisor must fit below 2**16.
  localparam int BAUD_CNT_W = 16;

  // One received frame as stored in the FIFO.
  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  // Clocks per bit, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/is_uart_rx_fifo.sv
// Generic synchronous FIFO with registered head (no fall-through).
// A push on a full FIFO is dropped unless a pop happens in the same cycle.
module is_uart_rx_fifo
  import is_pkg_uart_controller::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = rx_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         din_i,
  input  logic                     pop_i,
  output T                         dout_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  T               mem_d [DEPTH];
  T               head_q, head_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           pop_ok;
  logic           push_ok;
  logic           full;

  // Next-state for storage, pointers, occupancy and registered head.
  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    pop_ok  = pop_i & (cnt_q != '0);
    push_ok = push_i & (~full | pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = din_i;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    // Head tracks the entry at the next read pointer, including a word
    // written this very cycle; it holds its old value once empty.
    head_d  = head_q;
    if (cnt_d != '0) head_d = mem_d[rd_d];
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign full_o  = full;
  assign level_o = cnt_q;

endmodule

// File: rtl/is_uart_rx_ctrl.sv
// UART receive sequencer: rxd synchroniser, mid-bit sample strobe for the
// receive FSM, and a frame FIFO with frame-error / overflow status.
module is_uart_rx_ctrl
  import is_pkg_uart_controller::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rxd_i,
  output logic                          rxd_rg_o,
  output logic                          rx_ce_o,
  input  logic                          rxct_r_i,
  input  logic                          rx_data_en_i,
  input  logic [9:0]                    rx_data_t_i,
  output logic [7:0]                    m_data_o,
  output logic                          m_ferr_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  input  logic                          ovf_clr_i,
  output logic [7:0]                    ferr_cnt_o
);

  localparam int DIV_I = baud_div(CLK_HZ, BAUD);
  localparam logic [BAUD_CNT_W-1:0] DIV_M1  = BAUD_CNT_W'(DIV_I - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_M1 = BAUD_CNT_W'(DIV_I / 2 - 1);

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  // Shift the raw pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd_i};
  end

  // Synchroniser flops, idle-high at reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign rxd_rg_o = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------- baud
  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic                  ce_q, ce_d;
  logic                  hit;

  // Count while a frame is in progress; first strobe after half a bit
  // (start-bit centre), then one per bit. Idle aborts the count at once.
  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    ce_d    = 1'b0;
    hit     = first_q ? (cnt_q == HALF_M1) : (cnt_q == DIV_M1);
    if (rxct_r_i) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (hit) begin
      ce_d    = 1'b1;
      cnt_d   = '0;
      first_d = 1'b0;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Baud counter registers; the strobe is registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
      ce_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
      ce_q    <= ce_d;
    end
  end

  assign rx_ce_o = ce_q;

  // ---------------------------------------------------------------- capture
  rx_entry_t push_ent;
  rx_entry_t head_ent;
  logic      fifo_full;
  logic      pop;
  logic      drop;
  logic      ovf_q, ovf_d;
  logic [7:0] ferr_cnt_q, ferr_cnt_d;
  logic      unused_parity;

  // Parity is checked by the FSM, not here.
  assign unused_parity = rx_data_t_i[8];

  assign push_ent.ferr = rx_data_t_i[9];
  assign push_ent.data = rx_data_t_i[7:0];
  assign pop           = m_valid_o & m_ready_i;
  assign drop          = rx_data_en_i & fifo_full & ~pop;

  // Sticky overflow (a new drop beats a clear) and saturating error count.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
    ferr_cnt_d = ferr_cnt_q;
    if (rx_data_en_i && rx_data_t_i[9] && ferr_cnt_q != 8'hFF)
      ferr_cnt_d = ferr_cnt_q + 8'd1;
  end

  // Status registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q      <= 1'b0;
      ferr_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  assign ovf_o      = ovf_q;
  assign ferr_cnt_o = ferr_cnt_q;

  is_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rx_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_data_en_i),
    .din_i   (push_ent),
    .pop_i   (m_ready_i),
    .dout_o  (head_ent),
    .valid_o (m_valid_o),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  assign m_data_o = head_ent.data;
  assign m_ferr_o = head_ent.ferr;

endmodule

// File: tb/tb_is_uart_rx_ctrl.sv
// Bench for is_uart_rx_ctrl: a mock receive FSM drives frames, a queue
// scoreboard holds the bytes the FIFO is expected to return.
module tb_is_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          rxd_i = 1'b1;
  logic          rxd_rg_o;
  logic          rx_ce_o;
  logic          rxct_r_i = 1'b1;
  logic          rx_data_en_i = 1'b0;
  logic [9:0]    rx_data_t_i = '0;
  logic [7:0]    m_data_o;
  logic          m_ferr_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [LW-1:0] level_o;
  logic          ovf_o;
  logic          ovf_clr_i = 1'b0;
  logic [7:0]    ferr_cnt_o;

  is_uart_rx_ctrl #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rxd_i(rxd_i), .rxd_rg_o(rxd_rg_o),
    .rx_ce_o(rx_ce_o), .rxct_r_i(rxct_r_i), .rx_data_en_i(rx_data_en_i),
    .rx_data_t_i(rx_data_t_i), .m_data_o(m_data_o), .m_ferr_o(m_ferr_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .level_o(level_o),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i), .ferr_cnt_o(ferr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   nchk = 0;
  int   errs = 0;
  ent_t sb[$];
  int   lvl_m = 0;
  int   fcnt_m = 0;
  bit   ovf_m = 0;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One clock of mock-FSM / consumer activity; updates the model.
  task automatic step(input bit push, input logic [7:0] d, input bit fe,
                      input bit pop, input bit clr);
    bit pop_ok;
    bit drop;
    pop_ok       = pop && (lvl_m != 0);
    drop         = push && (lvl_m == DEPTH) && !pop_ok;
    rx_data_en_i = push;
    rx_data_t_i  = {fe, ^d, d};
    m_ready_i    = pop;
    ovf_clr_i    = clr;
    if (push && !drop) sb.push_back({fe, d});
    if (push && fe && fcnt_m != 255) fcnt_m++;
    lvl_m = lvl_m + ((push && !drop) ? 1 : 0) - (pop_ok ? 1 : 0);
    if (clr)  ovf_m = 0;
    if (drop) ovf_m = 1;
    cyc();
    rx_data_en_i = 1'b0;
    m_ready_i    = 1'b0;
    ovf_clr_i    = 1'b0;
  endtask

  // Pop everything, comparing each head against the scoreboard.
  task automatic drain_and_check(input string tag);
    ent_t e;
    for (int i = 0; i < 8 && lvl_m != 0; i++) begin
      e = (sb.size() != 0) ? sb.pop_front() : ent_t'('0);
      nchk++; if (m_valid_o !== 1'b1) begin errs++; $display("FAIL %s valid[%0d]: got %b want 1", tag, i, m_valid_o); end
      nchk++; if (m_data_o !== e.data) begin errs++; $display("FAIL %s data[%0d]: got %h want %h", tag, i, m_data_o, e.data); end
      nchk++; if (m_ferr_o !== e.ferr) begin errs++; $display("FAIL %s ferr[%0d]: got %b want %b", tag, i, m_ferr_o, e.ferr); end
      step(0, 8'h00, 0, 1, 0);
    end
    nchk++; if (m_valid_o !== 1'b0) begin errs++; $display("FAIL %s empty: valid got %b want 0", tag, m_valid_o); end
    nchk++; if (level_o !== '0) begin errs++; $display("FAIL %s empty: level got %0d want 0", tag, level_o); end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) cyc();
    nchk++; if (rxd_rg_o !== 1'b1)  begin errs++; $display("FAIL rst rxd_rg: got %b want 1", rxd_rg_o); end
    nchk++; if (rx_ce_o !== 1'b0)   begin errs++; $display("FAIL rst rx_ce: got %b want 0", rx_ce_o); end
    nchk++; if (m_valid_o !== 1'b0) begin errs++; $display("FAIL rst valid: got %b want 0", m_valid_o); end
    nchk++; if (m_data_o !== 8'h00) begin errs++; $display("FAIL rst data: got %h want 00", m_data_o); end
    nchk++; if (m_ferr_o !== 1'b0)  begin errs++; $display("FAIL rst ferr: got %b want 0", m_ferr_o); end
    nchk++; if (level_o !== '0)     begin errs++; $display("FAIL rst level: got %0d want 0", level_o); end
    nchk++; if (ovf_o !== 1'b0)     begin errs++; $display("FAIL rst ovf: got %b want 0", ovf_o); end
    nchk++; if (ferr_cnt_o !== 8'h00) begin errs++; $display("FAIL rst ferr_cnt: got %0d want 0", ferr_cnt_o); end
    rst_i = 1'b1;
    cyc();
  endtask

  task automatic test_sync();
    rxd_i = 1'b0;
    cyc();
    nchk++; if (rxd_rg_o !== 1'b1) begin errs++; $display("FAIL sync fall@1: got %b want 1", rxd_rg_o); end
    cyc();
    nchk++; if (rxd_rg_o !== 1'b0) begin errs++; $display("FAIL sync fall@2: got %b want 0", rxd_rg_o); end
    rxd_i = 1'b1;
    cyc();
    nchk++; if (rxd_rg_o !== 1'b0) begin errs++; $display("FAIL sync rise@1: got %b want 0", rxd_rg_o); end
    cyc();
    nchk++; if (rxd_rg_o !== 1'b1) begin errs++; $display("FAIL sync rise@2: got %b want 1", rxd_rg_o); end
  endtask

  task automatic test_baud();
    bit exp;
    rxct_r_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      exp = (k == 8) || (k > 8 && ((k - 8) % 16) == 0);
      nchk++; if (rx_ce_o !== exp) begin errs++; $display("FAIL baud ce@%0d: got %b want %b", k, rx_ce_o, exp); end
    end
    rxct_r_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      nchk++; if (rx_ce_o !== 1'b0) begin errs++; $display("FAIL baud idle@%0d: got %b want 0", k, rx_ce_o); end
    end
    // false start: abort after 5 clocks, then restart from half a bit
    rxct_r_i = 1'b0;
    repeat (5) cyc();
    rxct_r_i = 1'b1;
    cyc();
    rxct_r_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp = (k == 8);
      nchk++; if (rx_ce_o !== exp) begin errs++; $display("FAIL baud restart@%0d: got %b want %b", k, rx_ce_o, exp); end
    end
    rxct_r_i = 1'b1;
    cyc();
  endtask

  task automatic test_single_frame();
    int n;
    n = 0;
    rxct_r_i = 1'b0;
    for (int k = 1; k <= 152; k++) begin
      cyc();
      if (rx_ce_o === 1'b1) n++;
    end
    nchk++; if (n != 10) begin errs++; $display("FAIL frame strobes: got %0d want 10", n); end
    rxct_r_i = 1'b1;
    step(1, 8'h55, 0, 0, 0);
    nchk++; if (m_valid_o !== 1'b1) begin errs++; $display("FAIL single valid: got %b want 1", m_valid_o); end
    nchk++; if (level_o !== 3'(lvl_m)) begin errs++; $display("FAIL single level: got %0d want %0d", level_o, lvl_m); end
    drain_and_check("single");
  endtask

  task automatic test_ferr();
    step(1, 8'hA3, 1, 0, 0);
    nchk++; if (ferr_cnt_o !== 8'(fcnt_m)) begin errs++; $display("FAIL ferr cnt: got %0d want %0d", ferr_cnt_o, fcnt_m); end
    drain_and_check("ferr");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    nchk++; if (level_o !== 3'(lvl_m)) begin errs++; $display("FAIL ovf level: got %0d want %0d", level_o, lvl_m); end
    nchk++; if (ovf_o !== ovf_m) begin errs++; $display("FAIL ovf flag: got %b want %b", ovf_o, ovf_m); end
    drain_and_check("ovf");
    nchk++; if (m_data_o !== 8'h13) begin errs++; $display("FAIL ovf hold: got %h want 13", m_data_o); end
    step(0, 8'h00, 0, 0, 1);
    nchk++; if (ovf_o !== ovf_m) begin errs++; $display("FAIL ovf clear: got %b want %b", ovf_o, ovf_m); end
  endtask

  task automatic test_push_pop_full();
    ent_t e;
    for (int i = 0; i < 4; i++) step(1, 8'h60 + 8'(i), i[0], 0, 0);
    e = sb.pop_front();
    nchk++; if (m_data_o !== e.data) begin errs++; $display("FAIL pp head: got %h want %h", m_data_o, e.data); end
    step(1, 8'hC7, 0, 1, 0);
    nchk++; if (level_o !== 3'(lvl_m)) begin errs++; $display("FAIL pp level: got %0d want %0d", level_o, lvl_m); end
    nchk++; if (ovf_o !== ovf_m) begin errs++; $display("FAIL pp ovf: got %b want %b", ovf_o, ovf_m); end
    // clear and new overflow together: overflow must win
    step(1, 8'hEE, 0, 0, 1);
    nchk++; if (ovf_o !== ovf_m) begin errs++; $display("FAIL clr-vs-set ovf: got %b want %b", ovf_o, ovf_m); end
    drain_and_check("pp");
    step(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    ent_t e;
    for (int i = 0; i < 10; i++) begin
      if (lvl_m != 0) begin
        e = sb.pop_front();
        nchk++; if (m_data_o !== e.data || m_ferr_o !== e.ferr)
          begin errs++; $display("FAIL b2b[%0d]: got %b/%h want %b/%h", i, m_ferr_o, m_data_o, e.ferr, e.data); end
      end
      step(1, 8'($urandom), 1'($urandom), 1, 0);
    end
    nchk++; if (level_o !== 3'(lvl_m)) begin errs++; $display("FAIL b2b level: got %0d want %0d", level_o, lvl_m); end
    nchk++; if (ferr_cnt_o !== 8'(fcnt_m)) begin errs++; $display("FAIL b2b ferr_cnt: got %0d want %0d", ferr_cnt_o, fcnt_m); end
    drain_and_check("b2b");
  endtask

  task automatic test_ferr_saturate();
    for (int i = 0; i < 260; i++) step(1, 8'(i), 1, 0, 0);
    nchk++; if (ferr_cnt_o !== 8'(fcnt_m)) begin errs++; $display("FAIL sat ferr_cnt: got %0d want %0d", ferr_cnt_o, fcnt_m); end
    nchk++; if (ovf_o !== ovf_m) begin errs++; $display("FAIL sat ovf: got %b want %b", ovf_o, ovf_m); end
    drain_and_check("sat");
    step(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    step(1, 8'h5A, 1, 0, 0);
    step(1, 8'hB4, 0, 0, 0);
    rxd_i    = 1'b0;
    rxct_r_i = 1'b0;
    repeat (4) cyc();
    #2 rst_i = 1'b0;
    #1;
    nchk++; if (rxd_rg_o !== 1'b1)  begin errs++; $display("FAIL amid rxd_rg: got %b want 1", rxd_rg_o); end
    nchk++; if (m_valid_o !== 1'b0) begin errs++; $display("FAIL amid valid: got %b want 0", m_valid_o); end
    nchk++; if (m_data_o !== 8'h00) begin errs++; $display("FAIL amid data: got %h want 00", m_data_o); end
    nchk++; if (m_ferr_o !== 1'b0)  begin errs++; $display("FAIL amid ferr: got %b want 0", m_ferr_o); end
    nchk++; if (level_o !== '0)     begin errs++; $display("FAIL amid level: got %0d want 0", level_o); end
    nchk++; if (ferr_cnt_o !== 8'h00) begin errs++; $display("FAIL amid ferr_cnt: got %0d want 0", ferr_cnt_o); end
    nchk++; if (rx_ce_o !== 1'b0)   begin errs++; $display("FAIL amid rx_ce: got %b want 0", rx_ce_o); end
    sb.delete();
    lvl_m = 0; fcnt_m = 0; ovf_m = 0;
    rxd_i = 1'b1; rxct_r_i = 1'b1;
    cyc();
    rst_i = 1'b1;
    cyc();
    // the FIFO must work normally after the reset
    step(1, 8'h3C, 0, 0, 0);
    drain_and_check("post-reset");
  endtask

  initial begin
    test_reset();
    test_sync();
    test_baud();
    test_single_frame();
    test_ferr();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_ferr_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
